// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: packed issue layout decoded by the ALU, entry struct, opcodes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rs_pkg;

    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 6;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Issue word layout, LSB first: dest, imm, data2, data1, funct3, op.
    localparam int RS_DEST_LO   = 0;
    localparam int RS_DEST_HI   = RS_DEST_LO + RS_TAG_W - 1;
    localparam int RS_IMM_LO    = RS_DEST_HI + 1;
    localparam int RS_IMM_HI    = RS_IMM_LO + RS_XLEN - 1;
    localparam int RS_DATA2_LO  = RS_IMM_HI + 1;
    localparam int RS_DATA2_HI  = RS_DATA2_LO + RS_XLEN - 1;
    localparam int RS_DATA1_LO  = RS_DATA2_HI + 1;
    localparam int RS_DATA1_HI  = RS_DATA1_LO + RS_XLEN - 1;
    localparam int RS_FUNCT3_LO = RS_DATA1_HI + 1;
    localparam int RS_FUNCT3_HI = RS_FUNCT3_LO + 2;
    localparam int RS_OP_LO     = RS_FUNCT3_HI + 1;
    localparam int RS_OP_HI     = RS_OP_LO + 6;
    localparam int RS_WIDTH     = RS_OP_HI + 1;

    typedef struct packed {
        logic                vld;
        logic [6:0]          op;
        logic [2:0]          funct3;
        logic [RS_TAG_W-1:0] s1_tag;
        logic                s1_rdy;
        logic [RS_XLEN-1:0]  s1_dat;
        logic [RS_TAG_W-1:0] s2_tag;
        logic                s2_rdy;
        logic [RS_XLEN-1:0]  s2_dat;
        logic [RS_XLEN-1:0]  imm;
        logic [RS_TAG_W-1:0] dest;
    } rs_entry_t;

    function automatic logic [RS_WIDTH-1:0] rs_pack(
        input logic [6:0]          op,
        input logic [2:0]          funct3,
        input logic [RS_XLEN-1:0]  d1,
        input logic [RS_XLEN-1:0]  d2,
        input logic [RS_XLEN-1:0]  imm,
        input logic [RS_TAG_W-1:0] dest
    );
        return {op, funct3, d1, d2, imm, dest};
    endfunction

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB, flush and issue-slot bundle between the front end and the reservation station.
// Latency: wires only.
// Backpressure: disp_ready gates dispatch; issue_ready drains the issue slot.
interface rs_issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
);
    import rs_pkg::*;

    logic                     disp_valid;
    logic                     disp_ready;
    logic [6:0]               disp_op;
    logic [2:0]               disp_funct3;
    logic [TAG_W-1:0]         disp_src1_tag;
    logic [TAG_W-1:0]         disp_src2_tag;
    logic                     disp_src1_rdy;
    logic                     disp_src2_rdy;
    logic [XLEN-1:0]          disp_src1_data;
    logic [XLEN-1:0]          disp_src2_data;
    logic [XLEN-1:0]          disp_imm;
    logic [TAG_W-1:0]         disp_dest_tag;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [XLEN-1:0]          cdb_data;
    logic                     flush;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [RS_WIDTH-1:0]      rs_out;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output disp_valid, disp_op, disp_funct3, disp_src1_tag, disp_src2_tag,
               disp_src1_rdy, disp_src2_rdy, disp_src1_data, disp_src2_data,
               disp_imm, disp_dest_tag, cdb_valid, cdb_tag, cdb_data, flush, issue_ready,
        input  disp_ready, issue_valid, rs_out, count
    );

    modport slave (
        input  disp_valid, disp_op, disp_funct3, disp_src1_tag, disp_src2_tag,
               disp_src1_rdy, disp_src2_rdy, disp_src1_data, disp_src2_data,
               disp_imm, disp_dest_tag, cdb_valid, cdb_tag, cdb_data, flush, issue_ready,
        output disp_ready, issue_valid, rs_out, count
    );

endinterface

// File: rtl/rs_select.sv
// Oldest-ready picker: one-hot grant of the requesting entry with the largest age.
// Latency: combinational.
// Backpressure: none; caller masks req when the issue slot cannot load.
module rs_select #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         req,
    input  logic [DEPTH-1:0][AW-1:0] age,
    output logic [DEPTH-1:0]         grant,
    output logic                     found
);

    logic [AW-1:0] best_age;
    logic [AW-1:0] best_idx;

    // Linear max-age scan; equal ages (only possible after saturation) resolve to the lowest index.
    always_comb begin
        found    = 1'b0;
        best_age = '0;
        best_idx = '0;
        grant    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!found || age[i] > best_age)) begin
                found    = 1'b1;
                best_age = age[i];
                best_idx = AW'(i);
            end
        end
        if (found) grant[best_idx] = 1'b1;
    end

endmodule

// File: rtl/rs_issue_queue.sv
// ALU reservation station: CDB tag wakeup, oldest-ready select into a registered issue slot. Option: RS_WAKEUP_BYPASS_EN.
// Latency: dispatch-to-issue 2 edges; wakeup-to-issue 2 edges (1 with RS_WAKEUP_BYPASS_EN).
// Backpressure: disp_ready=0 when full (registered count); issue slot holds while issue_ready=0.
module rs_issue_queue
    import rs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = RS_TAG_W,
    parameter int XLEN  = RS_XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    rs_issue_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(DEPTH - 1);

    rs_entry_t                ent_q [DEPTH];
    logic [DEPTH-1:0][AW-1:0] age_q;
    logic [CW-1:0]            count_q;
    logic                     issue_vld_q;
    logic [RS_WIDTH-1:0]      rs_out_q;

    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_dat;
    logic             disp_rdy, disp_acc, load_en, found;
    logic [AW-1:0]    free_idx;
    logic [DEPTH-1:0] hit1, hit2, cand, req, grant;
    rs_entry_t        new_ent;
    logic [6:0]       sel_op;
    logic [2:0]       sel_f3;
    logic [XLEN-1:0]  sel_d1, sel_d2, sel_imm;
    logic [TAG_W-1:0] sel_dest;

    assign cdb_tag  = bus.cdb_tag;
    assign cdb_dat  = bus.cdb_data;
    assign disp_rdy = count_q < CW'(DEPTH);
    assign disp_acc = bus.disp_valid && disp_rdy;
    // The slot may take a new op when empty or being consumed this cycle.
    assign load_en  = !issue_vld_q || bus.issue_ready;
    assign req      = cand & {DEPTH{load_en}};

    // Lowest-index free entry, from registered valid bits.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].vld) free_idx = AW'(i);
        end
    end

    // CDB tag match per waiting operand, and the resulting issue candidates.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = bus.cdb_valid && !ent_q[i].s1_rdy && (ent_q[i].s1_tag == cdb_tag);
            hit2[i] = bus.cdb_valid && !ent_q[i].s2_rdy && (ent_q[i].s2_tag == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
            cand[i] = ent_q[i].vld && (ent_q[i].s1_rdy || hit1[i]) && (ent_q[i].s2_rdy || hit2[i]);
`else
            cand[i] = ent_q[i].vld && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
`endif
        end
    end

    // Incoming op also snoops the CDB so a same-cycle broadcast is not missed.
    always_comb begin
        new_ent        = '0;
        new_ent.vld    = 1'b1;
        new_ent.op     = bus.disp_op;
        new_ent.funct3 = bus.disp_funct3;
        new_ent.s1_tag = bus.disp_src1_tag;
        new_ent.s2_tag = bus.disp_src2_tag;
        new_ent.imm    = bus.disp_imm;
        new_ent.dest   = bus.disp_dest_tag;
        new_ent.s1_rdy = bus.disp_src1_rdy || (bus.cdb_valid && bus.disp_src1_tag == cdb_tag);
        new_ent.s2_rdy = bus.disp_src2_rdy || (bus.cdb_valid && bus.disp_src2_tag == cdb_tag);
        new_ent.s1_dat = bus.disp_src1_rdy ? bus.disp_src1_data : cdb_dat;
        new_ent.s2_dat = bus.disp_src2_rdy ? bus.disp_src2_data : cdb_dat;
    end

    rs_select #(.DEPTH(DEPTH), .AW(AW)) u_select (
        .req   (req),
        .age   (age_q),
        .grant (grant),
        .found (found)
    );

    // Mux the granted entry's fields; with bypass a still-missing operand takes the live CDB value.
    always_comb begin
        sel_op   = '0;
        sel_f3   = '0;
        sel_d1   = '0;
        sel_d2   = '0;
        sel_imm  = '0;
        sel_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_op   = ent_q[i].op;
                sel_f3   = ent_q[i].funct3;
                sel_imm  = ent_q[i].imm;
                sel_dest = ent_q[i].dest;
`ifdef RS_WAKEUP_BYPASS_EN
                sel_d1   = ent_q[i].s1_rdy ? ent_q[i].s1_dat : cdb_dat;
                sel_d2   = ent_q[i].s2_rdy ? ent_q[i].s2_dat : cdb_dat;
`else
                sel_d1   = ent_q[i].s1_dat;
                sel_d2   = ent_q[i].s2_dat;
`endif
            end
        end
    end

    // Entry array, ages, count and issue slot; flush overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            age_q       <= '0;
            count_q     <= '0;
            issue_vld_q <= 1'b0;
            rs_out_q    <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].vld <= 1'b0;
            count_q     <= '0;
            issue_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[i]) begin
                    ent_q[i].vld <= 1'b0;
                end else if (ent_q[i].vld) begin
                    if (hit1[i]) begin
                        ent_q[i].s1_rdy <= 1'b1;
                        ent_q[i].s1_dat <= cdb_dat;
                    end
                    if (hit2[i]) begin
                        ent_q[i].s2_rdy <= 1'b1;
                        ent_q[i].s2_dat <= cdb_dat;
                    end
                    if (disp_acc && age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
                end
            end
            if (disp_acc) begin
                ent_q[free_idx] <= new_ent;
                age_q[free_idx] <= '0;
            end
            if (load_en) begin
                issue_vld_q <= found;
                if (found) rs_out_q <= rs_pack(sel_op, sel_f3, sel_d1, sel_d2, sel_imm, sel_dest);
            end
            count_q <= count_q + CW'(disp_acc) - CW'(found);
        end
    end

    assign bus.disp_ready  = disp_rdy;
    assign bus.issue_valid = issue_vld_q;
    assign bus.rs_out      = rs_out_q;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: scoreboard of expected issue words plus latency/occupancy checks.
// Latency: n/a.
// Backpressure: exercises full queue and held issue slot.
module tb_rs_issue_queue;
    import rs_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;
`ifdef RS_WAKEUP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

    rs_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [RS_WIDTH-1:0] sb [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected issue word: op | funct3 | data1 | data2 | imm | dest, MSB to LSB.
    function automatic logic [RS_WIDTH-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                                  input logic [31:0] d1, input logic [31:0] d2,
                                                  input logic [31:0] imm, input logic [5:0] dest);
        return {op, f3, d1, d2, imm, dest};
    endfunction

    // Every consumed issue word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.issue_valid && bus.issue_ready) begin
            check("sb_avail", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) check("issue_word", 128'(bus.rs_out), 128'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3,
                        input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                        input logic [5:0] t2, input logic r2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [5:0] dest);
        bus.disp_valid     = 1'b1;
        bus.disp_op        = op;
        bus.disp_funct3    = f3;
        bus.disp_src1_tag  = t1;
        bus.disp_src1_rdy  = r1;
        bus.disp_src1_data = d1;
        bus.disp_src2_tag  = t2;
        bus.disp_src2_rdy  = r2;
        bus.disp_src2_data = d2;
        bus.disp_imm       = imm;
        bus.disp_dest_tag  = dest;
        tick();
        bus.disp_valid     = 1'b0;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || bus.issue_valid) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
        check({tag, "_count"}, 128'(bus.count), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_funct3 = '0;
        bus.disp_src1_tag = '0; bus.disp_src2_tag = '0; bus.disp_src1_rdy = 1'b0;
        bus.disp_src2_rdy = 1'b0; bus.disp_src1_data = '0; bus.disp_src2_data = '0;
        bus.disp_imm = '0; bus.disp_dest_tag = '0; bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0; bus.cdb_data = '0; bus.flush = 1'b0; bus.issue_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_issue_valid", 128'(bus.issue_valid), 128'(0));
        check("rst_count", 128'(bus.count), 128'(0));
        check("rst_disp_ready", 128'(bus.disp_ready), 128'(1));
        check("rst_rs_out", 128'(bus.rs_out), 128'(0));

        // Single ready add: two edges to issue.
        sb.push_back(model(OP_R, 3'd0, 32'd5, 32'd7, 32'd0, 6'd1));
        disp(OP_R, 3'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 32'd0, 6'd1);
        check("t1_vld_after_disp", 128'(bus.issue_valid), 128'(0));
        check("t1_count_after_disp", 128'(bus.count), 128'(1));
        tick();
        check("t1_vld_after_load", 128'(bus.issue_valid), 128'(1));
        check("t1_count_after_load", 128'(bus.count), 128'(0));
        drain("t1");

        // Fill all entries waiting on tag 10, overflow attempt, then one wakeup issues oldest first.
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(model(OP_I, 3'(i), 32'h100, 32'(i * 3), 32'(i), 6'(40 + i)));
            disp(OP_I, 3'(i), 6'd10, 1'b0, 32'd0, 6'd0, 1'b1, 32'(i * 3), 32'(i), 6'(40 + i));
        end
        check("t2_count_full", 128'(bus.count), 128'(DEPTH));
        check("t2_disp_ready_full", 128'(bus.disp_ready), 128'(0));
        disp(OP_R, 3'd0, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 32'd0, 6'd63);
        check("t2_count_after_overflow", 128'(bus.count), 128'(DEPTH));
        tick();
        tick();
        cdb(6'd10, 32'h100);
        drain("t2");

        // A waits on tag 3, B on tag 4: broadcast 4 first so B leaves first.
        sb.push_back(model(OP_R, 3'd1, 32'h44, 32'hB2, 32'd0, 6'd21));
        sb.push_back(model(OP_R, 3'd1, 32'h33, 32'hA2, 32'd0, 6'd20));
        disp(OP_R, 3'd1, 6'd3, 1'b0, 32'd0, 6'd0, 1'b1, 32'hA2, 32'd0, 6'd20);
        disp(OP_R, 3'd1, 6'd4, 1'b0, 32'd0, 6'd0, 1'b1, 32'hB2, 32'd0, 6'd21);
        cdb(6'd4, 32'h44);
        tick();
        tick();
        cdb(6'd3, 32'h33);
        drain("t3a");

        // Both woken by the same broadcast: older one first.
        sb.push_back(model(OP_R, 3'd2, 32'h55, 32'h1, 32'd0, 6'd22));
        sb.push_back(model(OP_R, 3'd2, 32'h55, 32'h2, 32'd0, 6'd23));
        disp(OP_R, 3'd2, 6'd5, 1'b0, 32'd0, 6'd0, 1'b1, 32'h1, 32'd0, 6'd22);
        disp(OP_R, 3'd2, 6'd5, 1'b0, 32'd0, 6'd0, 1'b1, 32'h2, 32'd0, 6'd23);
        cdb(6'd5, 32'h55);
        drain("t3b");

        // Broadcast in the dispatch cycle is captured.
        sb.push_back(model(OP_R, 3'd0, 32'hDEAD, 32'd1, 32'd0, 6'd24));
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd9;
        bus.cdb_data  = 32'hDEAD;
        disp(OP_R, 3'd0, 6'd9, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1, 32'd0, 6'd24);
        bus.cdb_valid = 1'b0;
        drain("t4");

        // Held slot stays stable, then flush clears slot and queue.
        bus.issue_ready = 1'b0;
        disp(OP_LUI, 3'd0, 6'd0, 1'b1, 32'h11, 6'd0, 1'b1, 32'h12, 32'h1000, 6'd30);
        disp(OP_LUI, 3'd0, 6'd0, 1'b1, 32'h21, 6'd0, 1'b1, 32'h22, 32'h2000, 6'd31);
        check("t5_vld", 128'(bus.issue_valid), 128'(1));
        check("t5_count", 128'(bus.count), 128'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_word", 128'(bus.rs_out),
                  128'(model(OP_LUI, 3'd0, 32'h11, 32'h12, 32'h1000, 6'd30)));
            check("t5_hold_vld", 128'(bus.issue_valid), 128'(1));
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t5_flush_vld", 128'(bus.issue_valid), 128'(0));
        check("t5_flush_count", 128'(bus.count), 128'(0));
        bus.issue_ready = 1'b1;
        repeat (4) tick();
        check("t5_disp_ready", 128'(bus.disp_ready), 128'(1));

        // Wakeup-to-issue latency, one edge shorter with bypass.
        sb.push_back(model(OP_I, 3'd2, 32'h77, 32'd5, 32'd9, 6'd33));
        disp(OP_I, 3'd2, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd5, 32'd9, 6'd33);
        tick();
        tick();
        cdb(6'd20, 32'h77);
        check("t6_vld_edge_n", 128'(bus.issue_valid), 128'(BYP));
        tick();
        check("t6_vld_edge_n1", 128'(bus.issue_valid), 128'(!BYP));
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
